seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_shreg.sv | 36 +++
 rtl/seq_pattern_tx.sv | 116 +++++++++++
 tb/tb_seq_pattern_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// The GAP state is only reachable when SEQ_TX_GAP_EN is defined.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } seq_state_t;

    localparam int PAT_W_DEFAULT = 4;
    localparam int CNT_W_DEFAULT = 4;
    localparam int GAP_CYCLES    = 1;

endpackage

// File: rtl/seq_shreg.sv
// Loadable MSB-first shift register with a count of bits still to be sent.
// Zeros shift in, so the register is all-zero once every bit has gone out.
module seq_shreg
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEFAULT,
    parameter int BL_W  = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] data,
    output logic             msb,
    output logic [BL_W-1:0]  bits_left
);

    logic [PAT_W-1:0] sr;

    // Load wins over shift so a back-to-back reload never loses the first bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr        <= '0;
            bits_left <= '0;
        end else if (load) begin
            sr        <= data;
            bits_left <= BL_W'(PAT_W);
        end else if (shift) begin
            sr        <= {sr[PAT_W-2:0], 1'b0};
            bits_left <= bits_left - BL_W'(1);
        end
    end

    assign msb = sr[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serializes a latched pattern MSB first, repeat_cnt+1 times, then pulses done.
// Define SEQ_TX_GAP_EN to insert one idle GAP cycle between repetitions.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);

    localparam int BL_W = $clog2(PAT_W + 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] pat_next;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_next;
    logic             load;
    logic             shift;
    logic [PAT_W-1:0] load_data;
    logic [BL_W-1:0]  bits_left;

    // w comes straight from the shift register flop, which is cleared by
    // shifting out the final bit, so it is already 0 outside SHIFT.
    seq_shreg #(
        .PAT_W (PAT_W),
        .BL_W  (BL_W)
    ) u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .shift     (shift),
        .data      (load_data),
        .msb       (w),
        .bits_left (bits_left)
    );

    always_comb begin
        state_next = state;
        pat_next   = pat_q;
        rem_next   = rem_q;
        load       = 1'b0;
        shift      = 1'b0;
        load_data  = pat_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    load_data  = pattern;
                    pat_next   = pattern;
                    rem_next   = repeat_cnt;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bits_left == BL_W'(1)) begin
                    if (rem_q != '0) begin
                        rem_next = rem_q - CNT_W'(1);
`ifdef SEQ_TX_GAP_EN
                        shift      = 1'b1;
                        state_next = GAP;
`else
                        load = 1'b1;
`endif
                    end else begin
                        shift      = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    shift = 1'b1;
                end
            end
            // GAP_CYCLES is 1, so the reload happens on the only GAP cycle.
            GAP: begin
                load       = 1'b1;
                state_next = SHIFT;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with w.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pat_q   <= '0;
            rem_q   <= '0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            pat_q   <= pat_next;
            rem_q   <= rem_next;
            w_valid <= (state_next == SHIFT);
            busy    <= (state_next == SHIFT) || (state_next == GAP);
            done    <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: table of transmissions plus corner sequences.
// Expectations follow SEQ_TX_GAP_EN when the bench is built with that macro.
module tb_seq_pattern_tx;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
`ifdef SEQ_TX_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic w;
        logic w_valid;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        logic [PAT_W-1:0] pat;
        logic [CNT_W-1:0] rep;
        int               done_cyc;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   done_cnt    = 0;
    int   done_at     = -1;

    seq_pattern_tx #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .w          (w),
        .w_valid    (w_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic push_rec(input logic we, input logic ve, input logic be, input logic de);
        exp_q.push_back(exp_t'({we, ve, be, de}));
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_rec(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected per-cycle outputs for one accepted start, ending with the done cycle.
    task automatic push_tx(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep);
        for (int t = 0; t <= int'(rep); t++) begin
            for (int i = PAT_W - 1; i >= 0; i--) push_rec(pat[i], 1'b1, 1'b1, 1'b0);
            if (GAP != 0 && t < int'(rep)) push_rec(1'b0, 1'b0, 1'b1, 1'b0);
        end
        push_rec(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic apply_stimulus(input logic st, input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r);
        start      = st;
        pattern    = p;
        repeat_cnt = r;
        cyc        = 0;
        done_cnt   = 0;
        done_at    = -1;
    endtask

    task automatic check_output(input string tag);
        exp_t e;
        exp_t a;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        a = exp_t'({w, w_valid, busy, done});
        if (done === 1'b1) begin
            done_cnt++;
            done_at = cyc;
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: no expected entry, got w/v/b/d=%b", tag, cyc, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                miscompares++;
                $display("[TB] FAIL %s cycle %0d: got w/v/b/d=%b, expected %b", tag, cyc, a, e);
            end
        end
    endtask

    task automatic run_out(input string tag);
        while (exp_q.size() > 0) check_output(tag);
    endtask

    task automatic check_value(input string tag, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    initial begin
        // Reset with start high: start must not be accepted.
        rst_n      = 1'b0;
        start      = 1'b1;
        pattern    = 4'b1111;
        repeat_cnt = 2'd3;
        push_idle(2);
        check_output("reset");
        check_output("reset");
        rst_n = 1'b1;
        start = 1'b0;
        push_idle(1);
        check_output("idle_after_reset");

        vecs[0] = '{4'b1011, 2'd0, 5};
        vecs[1] = '{4'b1011, 2'd2, 13 + 2 * GAP};
        vecs[2] = '{4'b0110, 2'd1, 9 + GAP};
        vecs[3] = '{4'b1000, 2'd3, 17 + 3 * GAP};
        vecs[4] = '{4'b0001, 2'd0, 5};
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, vecs[i].pat, vecs[i].rep);
            push_tx(vecs[i].pat, vecs[i].rep);
            push_idle(1);
            check_output("vec_stream");
            start = 1'b0;
            run_out("vec_stream");
            check_value("vec_done_cycle", done_at, vecs[i].done_cyc);
            check_value("vec_done_count", done_cnt, 1);
        end

        // Restart while busy and start during DONE are both dropped.
        apply_stimulus(1'b1, 4'b1011, 2'd0);
        push_tx(4'b1011, 2'd0);
        push_idle(2);
        check_output("restart_busy");
        check_output("restart_busy");
        start      = 1'b1;
        pattern    = 4'b0000;
        repeat_cnt = 2'd3;
        check_output("restart_busy");
        start = 1'b0;
        check_output("restart_busy");
        check_output("restart_busy");
        start = 1'b1;
        check_output("start_in_done");
        start = 1'b0;
        run_out("start_in_done");
        check_value("restart_done_count", done_cnt, 1);
        check_value("restart_done_cycle", done_at, 5);

        // Reset mid-transmission aborts with no done pulse.
        apply_stimulus(1'b1, 4'b1011, 2'd2);
        push_rec(1'b1, 1'b1, 1'b1, 1'b0);
        push_rec(1'b0, 1'b1, 1'b1, 1'b0);
        push_rec(1'b1, 1'b1, 1'b1, 1'b0);
        push_idle(2);
        check_output("abort");
        start = 1'b0;
        check_output("abort");
        check_output("abort");
        rst_n = 1'b0;
        start = 1'b1;
        check_output("abort_reset");
        rst_n = 1'b1;
        start = 1'b0;
        check_output("abort_idle");
        check_value("abort_done_count", done_cnt, 0);

        apply_stimulus(1'b1, 4'b1101, 2'd1);
        push_tx(4'b1101, 2'd1);
        push_idle(1);
        check_output("after_abort");
        start = 1'b0;
        run_out("after_abort");
        check_value("after_abort_done_cycle", done_at, 9 + GAP);

        // All-ones repeat count with start held: re-accepted right after DONE.
        apply_stimulus(1'b1, 4'b1011, 2'd3);
        push_tx(4'b1011, 2'd3);
        push_idle(1);
        push_tx(4'b0110, 2'd0);
        push_idle(1);
        check_output("held_start");
        pattern    = 4'b0110;
        repeat_cnt = 2'd0;
        for (int k = 0; k < 18 + 3 * GAP; k++) check_output("held_start");
        start = 1'b0;
        run_out("held_start");
        check_value("held_done_count", done_cnt, 2);
        check_value("held_last_done_cycle", done_at, 23 + 3 * GAP);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
